// File: rtl/fifo_wr_arbiter_ctrl.sv
// Write-side controller of the async FIFO.
// Picks one of NREQ requesters per cycle in round-robin order, drives the
// memory write port, owns the binary/Gray write pointer and raises full.
//
// Handshake: req[i] is held until granted. gnt[i] is combinational and one-hot.
// gnt[i]=1 means the slice wdata[i] is written on this clk edge, so the
// requester may drop req[i] or change its data on the next cycle.
// No grant is issued while full=1.
module fifo_wr_arbiter_ctrl #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8,
   parameter int NREQ   = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*DATA_W-1:0]   wdata,
   output logic [NREQ-1:0]          gnt,
   output logic                     wr_en,
   output logic [ADDR_W-1:0]        wr_addr,
   output logic [DATA_W-1:0]        wr_data,
   output logic [ADDR_W:0]          wptr_gray,
   input  logic [ADDR_W:0]          rptr_sync,
   output logic                     full
);

   localparam int PTR_W = ADDR_W + 1;
   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PTR_W-1:0] wbin;
   logic [PTR_W-1:0] wbin_next;
   logic [PTR_W-1:0] wgray_next;
   logic [PTR_W-1:0] rptr_full_pat;
   logic             full_next;
   logic [IDX_W-1:0] last_gnt;
   logic [IDX_W-1:0] gnt_idx;
   logic             req_hit;

   // Round-robin search: first requester after last_gnt, wrapping modulo NREQ.
   always_comb begin
      req_hit = 1'b0;
      gnt_idx = '0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!req_hit && req[IDX_W'((int'(last_gnt) + k) % NREQ)]) begin
            req_hit = 1'b1;
            gnt_idx = IDX_W'((int'(last_gnt) + k) % NREQ);
         end
      end
   end

   // Grant decode and write-port mux; a full FIFO blocks every grant.
   always_comb begin
      gnt     = '0;
      wr_data = '0;
      if (req_hit && !full) begin
         gnt[gnt_idx] = 1'b1;
      end
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            wr_data = wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   assign wr_en   = |gnt;
   assign wr_addr = wbin[ADDR_W-1:0];

   // Pointer after this cycle's write and the full comparison against the
   // synchronised read pointer (top two Gray bits inverted = one lap ahead).
   always_comb begin
      wbin_next     = wbin + {{(PTR_W-1){1'b0}}, wr_en};
      wgray_next    = wbin_next ^ (wbin_next >> 1);
      rptr_full_pat = {~rptr_sync[ADDR_W:ADDR_W-1], rptr_sync[ADDR_W-2:0]};
      full_next     = (wgray_next == rptr_full_pat);
   end

   // State register: pointers, full flag and arbitration history.
   always_ff @(posedge clk) begin
      if (rst) begin
         wbin      <= '0;
         wptr_gray <= '0;
         full      <= 1'b0;
         last_gnt  <= IDX_W'(NREQ - 1);
      end else begin
         wbin      <= wbin_next;
         wptr_gray <= wgray_next;
         full      <= full_next;
         if (wr_en) begin
            last_gnt <= gnt_idx;
         end
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter_ctrl.sv
// Bench for fifo_wr_arbiter_ctrl: directed phases plus randomized traffic,
// checked against a counting model (writes/reads as integers, occupancy
// as their difference, round-robin as a plain search over requester indices).
module tb_fifo_wr_arbiter_ctrl;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 8;
   localparam int NREQ   = 4;
   localparam int PTR_W  = ADDR_W + 1;
   localparam int DEPTH  = 1 << ADDR_W;
   localparam int LAP    = 1 << PTR_W;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [NREQ-1:0]        req;
   logic [NREQ*DATA_W-1:0] wdata;
   logic [NREQ-1:0]        gnt;
   logic                   wr_en;
   logic [ADDR_W-1:0]      wr_addr;
   logic [DATA_W-1:0]      wr_data;
   logic [PTR_W-1:0]       wptr_gray;
   logic [PTR_W-1:0]       rptr_sync;
   logic                   full;

   fifo_wr_arbiter_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NREQ(NREQ)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .wdata     (wdata),
      .gnt       (gnt),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wptr_gray (wptr_gray),
      .rptr_sync (rptr_sync),
      .full      (full)
   );

   // ---------------- reference model ----------------
   int  wcount;      // total writes since reset
   int  rcount;      // total reads the read side has published
   int  last_idx;    // last granted requester
   bit  full_m;      // registered full flag
   int  grant_idx;   // this cycle's expected grant, -1 = none
   int  n_checks = 0;
   int  n_errors = 0;
   logic [ADDR_W+DATA_W-1:0] exp_q[$];

   function automatic logic [PTR_W-1:0] to_gray(input int n);
      logic [PTR_W-1:0] b;
      b = PTR_W'(n % LAP);
      return b ^ (b >> 1);
   endfunction

   assign rptr_sync = to_gray(rcount);

   function automatic int pick(input logic [NREQ-1:0] r);
      int c;
      if (full_m) return -1;
      for (int k = 1; k <= NREQ; k++) begin
         c = (last_idx + k) % NREQ;
         if (r[c]) return c;
      end
      return -1;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   // One clock cycle: compare outputs at the falling edge, advance model at
   // the rising edge, return 1 time unit later so callers can drive inputs.
   task automatic cycle();
      logic [NREQ-1:0]          exp_gnt;
      logic [DATA_W-1:0]        exp_data;
      logic [ADDR_W+DATA_W-1:0] obs;
      @(negedge clk);
      grant_idx = pick(req);
      exp_gnt   = '0;
      exp_data  = '0;
      if (grant_idx >= 0) begin
         exp_gnt[grant_idx] = 1'b1;
         exp_data = wdata[grant_idx*DATA_W +: DATA_W];
         exp_q.push_back({ADDR_W'(wcount % DEPTH), exp_data});
      end
      check("gnt", gnt, exp_gnt);
      check("wr_en", wr_en, exp_gnt != 0);
      check("wr_data", wr_data, exp_data);
      check("wr_addr", wr_addr, wcount % DEPTH);
      check("wptr_gray", wptr_gray, to_gray(wcount));
      check("full", full, full_m);
      // scoreboard: every observed write must match the oldest expected one
      if (wr_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("sb_wr_en", wr_en, 1'b0);
         end else begin
            obs = {wr_addr, wr_data};
            check("sb_write", obs, exp_q.pop_front());
         end
      end
      @(posedge clk);
      if (rst) begin
         wcount   = 0;
         last_idx = NREQ - 1;
         full_m   = 1'b0;
      end else begin
         if (grant_idx >= 0) begin
            wcount++;
            last_idx = grant_idx;
         end
         full_m = ((wcount - rcount) == DEPTH);
      end
      #1;
   endtask

   // Reset for n cycles; the first cycle is left unchecked when DUT state
   // may still be unknown.
   task automatic apply_reset(input int n, input bit chk_first);
      rst    = 1'b1;
      rcount = 0;
      for (int i = 0; i < n; i++) begin
         if (i == 0 && !chk_first) begin
            @(posedge clk);
            wcount   = 0;
            last_idx = NREQ - 1;
            full_m   = 1'b0;
            #1;
         end else begin
            cycle();
         end
      end
      rst = 1'b0;
   endtask

   task automatic rand_data();
      wdata = (NREQ*DATA_W)'($urandom);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int cyc;
      logic [NREQ-1:0] keep;
      rst = 1'b1; req = '0; wdata = '0;
      wcount = 0; rcount = 0; last_idx = NREQ - 1; full_m = 1'b0; grant_idx = -1;

      // reset held with all requesters active
      req = 4'b1111;
      apply_reset(2, 1'b0);
      check("rst_wptr_gray", wptr_gray, 5'b00000);
      check("rst_full", full, 1'b0);
      check("rst_wr_addr", wr_addr, 4'd0);

      // round-robin with every requester active
      for (int i = 0; i < 5; i++) begin
         rand_data();
         cycle();
      end

      // fill with a single requester
      req = 4'b0100;
      apply_reset(1, 1'b0);
      for (int i = 0; i < 20; i++) begin
         rand_data();
         cycle();
      end
      check("fill_gray", wptr_gray, 5'b11000);
      check("fill_full", full, 1'b1);

      // drain one slot, refill it
      rcount = 1;
      for (int i = 0; i < 3; i++) begin
         rand_data();
         cycle();
      end
      check("drain_gray", wptr_gray, 5'b11001);
      check("drain_full", full, 1'b1);

      // wrap: 32 writes with reads keeping occupancy below the depth
      req = 4'b1111;
      apply_reset(1, 1'b0);
      cyc = 0;
      while (wcount < 2 * DEPTH && cyc < 200) begin
         rand_data();
         cycle();
         cyc++;
         if (rcount < wcount && ($urandom_range(0, 3) != 0 || (wcount - rcount) >= 12))
            rcount++;
      end
      check("wrap_gray", wptr_gray, 5'b00000);
      check("wrap_addr", wr_addr, 4'd0);

      // randomized traffic: slow reader then fast reader
      for (int i = 0; i < 400; i++) begin
         keep = req;
         if (grant_idx >= 0) keep[grant_idx] = 1'b0;
         req = keep | (NREQ'($urandom) & NREQ'($urandom));
         rand_data();
         cycle();
         if (rcount < wcount && $urandom_range(0, (i < 200) ? 3 : 1) == 0)
            rcount++;
      end

      // reset in the middle of traffic
      req = 4'b1111;
      apply_reset(1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         rand_data();
         cycle();
      end
      apply_reset(1, 1'b1);
      check("midrst_gray", wptr_gray, 5'b00000);
      check("midrst_full", full, 1'b0);
      rand_data();
      cycle();
      check("midrst_addr", wr_addr, 4'd1);

      // ---------------- final report ----------------
      check("sb_leftover", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   // global time bound
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
